// File: rtl/out_port_uart_tx.sv
// out_port_uart_tx: detects changes of the CPU out_port, queues each new value and sends it as a UART frame on tx.
// Optional even parity bit between data and stop is compiled in with OUT_PORT_UART_PARITY_EN.
module out_port_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       clk_f,
    input  logic       rst_n,
    input  logic [7:0] out_port,
    output logic       tx,
    output logic       busy,
    output logic       fifo_full,
    output logic [7:0] ovf_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   PTR_ONE  = {{AW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef OUT_PORT_UART_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    state_t          state_r, state_s;
    logic [7:0]      prev_r;
    logic [7:0]      mem_r [FIFO_DEPTH];
    logic [AW:0]     wr_ptr_r, rd_ptr_r, wr_ptr_s, rd_ptr_s;
    logic            empty_s, full_s, full_next_s;
    logic            push_req_s, push_ok_s, pop_s;
    logic [7:0]      sr_r, sr_s;
    logic [2:0]      bit_idx_r, bit_idx_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic            tx_r, tx_s, busy_r, fifo_full_r;
    logic [7:0]      ovf_r, ovf_s;
`ifdef OUT_PORT_UART_PARITY_EN
    logic            par_r, par_s;
`endif

    // FIFO bookkeeping: change detect, pop/push acceptance, next pointers and overflow count.
    always_comb begin
        empty_s     = (wr_ptr_r == rd_ptr_r);
        full_s      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        push_req_s  = (out_port != prev_r);
        pop_s       = (state_r == IDLE) && !empty_s;
        push_ok_s   = push_req_s && (!full_s || pop_s);
        wr_ptr_s    = push_ok_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
        rd_ptr_s    = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
        full_next_s = (wr_ptr_s[AW] != rd_ptr_s[AW]) && (wr_ptr_s[AW-1:0] == rd_ptr_s[AW-1:0]);
        if (push_req_s && !push_ok_s && (ovf_r != 8'hFF)) begin
            ovf_s = ovf_r + 8'd1;
        end else begin
            ovf_s = ovf_r;
        end
    end

    // Frame sequencer; tx is derived from the next state so the registered line lines up with the state.
    always_comb begin
        state_s   = state_r;
        sr_s      = sr_r;
        bit_idx_s = bit_idx_r;
        cnt_s     = cnt_r;
`ifdef OUT_PORT_UART_PARITY_EN
        par_s     = par_r;
`endif
        case (state_r)
            IDLE: begin
                if (pop_s) begin
                    state_s = START;
                    sr_s    = mem_r[rd_ptr_r[AW-1:0]];
                    cnt_s   = {CW{1'b0}};
`ifdef OUT_PORT_UART_PARITY_EN
                    par_s   = even_parity(mem_r[rd_ptr_r[AW-1:0]]);
`endif
                end else begin
                    cnt_s   = {CW{1'b0}};
                end
            end
            START: begin
                if (cnt_r == CNT_LAST) begin
                    state_s   = DATA;
                    bit_idx_s = 3'd0;
                    cnt_s     = {CW{1'b0}};
                end else begin
                    cnt_s     = cnt_r + CNT_ONE;
                end
            end
            DATA: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s = {CW{1'b0}};
                    if (bit_idx_r == 3'd7) begin
`ifdef OUT_PORT_UART_PARITY_EN
                        state_s = PARITY;
`else
                        state_s = STOP;
`endif
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                        sr_s      = {1'b0, sr_r[7:1]};
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
`ifdef OUT_PORT_UART_PARITY_EN
            PARITY: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = STOP;
                    cnt_s   = {CW{1'b0}};
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
`endif
            STOP: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = IDLE;
                    cnt_s   = {CW{1'b0}};
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CW{1'b0}};
            end
        endcase

        case (state_s)
            IDLE:    tx_s = 1'b1;
            START:   tx_s = 1'b0;
            DATA:    tx_s = sr_s[0];
`ifdef OUT_PORT_UART_PARITY_EN
            PARITY:  tx_s = par_s;
`endif
            STOP:    tx_s = 1'b1;
            default: tx_s = 1'b1;
        endcase
    end

    // State, pointers and registered outputs.
    always_ff @(posedge clk_f) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            prev_r      <= 8'h00;
            wr_ptr_r    <= {(AW+1){1'b0}};
            rd_ptr_r    <= {(AW+1){1'b0}};
            sr_r        <= 8'h00;
            bit_idx_r   <= 3'd0;
            cnt_r       <= {CW{1'b0}};
            tx_r        <= 1'b1;
            busy_r      <= 1'b0;
            fifo_full_r <= 1'b0;
            ovf_r       <= 8'h00;
`ifdef OUT_PORT_UART_PARITY_EN
            par_r       <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            prev_r      <= out_port;
            wr_ptr_r    <= wr_ptr_s;
            rd_ptr_r    <= rd_ptr_s;
            sr_r        <= sr_s;
            bit_idx_r   <= bit_idx_s;
            cnt_r       <= cnt_s;
            tx_r        <= tx_s;
            busy_r      <= (state_s != IDLE);
            fifo_full_r <= full_next_s;
            ovf_r       <= ovf_s;
`ifdef OUT_PORT_UART_PARITY_EN
            par_r       <= par_s;
`endif
        end
    end

    // FIFO storage needs no reset: entries are only read between valid pointers.
    always_ff @(posedge clk_f) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= out_port;
        end
    end

    assign tx        = tx_r;
    assign busy      = busy_r;
    assign fifo_full = fifo_full_r;
    assign ovf_cnt   = ovf_r;
endmodule

// File: tb/tb_out_port_uart_tx.sv
// Bench for out_port_uart_tx: a queue-and-frame-position model checked every cycle, plus literal pins.
module tb_out_port_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef OUT_PORT_UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = CPB * NBITS;
    localparam int MAXC  = 30000;

    logic       clk_f = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] out_port = 8'h00;
    logic       tx, busy, fifo_full;
    logic [7:0] ovf_cnt;

    out_port_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk_f(clk_f), .rst_n(rst_n), .out_port(out_port),
        .tx(tx), .busy(busy), .fifo_full(fifo_full), .ovf_cnt(ovf_cnt)
    );

    always #5 clk_f = ~clk_f;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit hist_tx [MAXC];
    bit hist_busy [MAXC];

    // model: pending bytes, last seen port value, current frame byte and position in the frame
    logic [7:0] q [$];
    logic [7:0] prev_m = 8'h00;
    logic [7:0] cur_m = 8'h00;
    logic [7:0] ovf_m = 8'h00;
    bit         act_m = 1'b0;
    int         pos_m = 0;

    function automatic bit frame_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
`ifdef OUT_PORT_UART_PARITY_EN
        if (k == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic model_edge();
        bit push, pop;
        int sz;
        if (!rst_n) begin
            q.delete();
            prev_m = 8'h00; ovf_m = 8'h00; act_m = 1'b0; pos_m = 0;
        end else begin
            push = (out_port != prev_m);
            pop  = !act_m && (q.size() > 0);
            sz   = q.size();
            if (pop) cur_m = q.pop_front();
            if (push) begin
                if (sz < DEPTH || pop) q.push_back(out_port);
                else if (ovf_m != 8'hFF) ovf_m = ovf_m + 8'd1;
            end
            prev_m = out_port;
            if (pop) begin
                act_m = 1'b1; pos_m = 0;
            end else if (act_m) begin
                pos_m++;
                if (pos_m == FRAME) begin act_m = 1'b0; pos_m = 0; end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // one clock: model follows the edge, then DUT outputs are compared on the falling edge
    task automatic step();
        bit etx;
        @(posedge clk_f);
        model_edge();
        cyc++;
        @(negedge clk_f);
        if (cyc < MAXC) begin
            hist_tx[cyc] = tx;
            hist_busy[cyc] = busy;
        end
        etx = act_m ? frame_bit(cur_m, pos_m / CPB) : 1'b1;
        check("tx", {31'd0, tx}, {31'd0, etx});
        check("busy", {31'd0, busy}, {31'd0, act_m});
        check("fifo_full", {31'd0, fifo_full}, {31'd0, (q.size() == DEPTH)});
        check("ovf_cnt", {24'd0, ovf_cnt}, {24'd0, ovf_m});
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input int n, input logic [7:0] port);
        rst_n = 1'b0; out_port = port;
        steps(n);
        rst_n = 1'b1;
    endtask

    function automatic logic [7:0] decode(input int start);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = hist_tx[start + CPB * (i + 1)];
        return b;
    endfunction

    function automatic int busy_count(input int from, input int len);
        int c = 0;
        for (int k = from; k < from + len; k++) c += int'(hist_busy[k]);
        return c;
    endfunction

    initial begin
        int n, cnt, hold;
        int ebits [NBITS];
        logic [7:0] v;

        // reset state
        steps(3);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_full", {31'd0, fifo_full}, 32'd0);
        check("reset_ovf", {24'd0, ovf_cnt}, 32'd0);
        rst_n = 1'b1;
        step();

        // single byte 0xA5
`ifdef OUT_PORT_UART_PARITY_EN
        ebits = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
        ebits = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
`endif
        n = cyc; out_port = 8'hA5;
        steps(60);
        check("single_pre_start", {31'd0, hist_tx[n+1]}, 32'd1);
        for (int k = 0; k < NBITS; k++)
            check("single_bit", {31'd0, hist_tx[n + 2 + CPB * k]}, ebits[k]);
        check("single_busy_len", busy_count(n, 60), FRAME);

        // identical value held: one frame only
        n = cyc; out_port = 8'h3C;
        steps(200);
        cnt = 0;
        for (int k = n + 1; k <= n + 200; k++)
            if (hist_busy[k] && !hist_busy[k-1]) cnt++;
        check("no_repush_frames", cnt, 32'd1);
        check("no_repush_byte", {24'd0, decode(n + 2)}, 32'h3C);

        // overflow: 7 changes on consecutive idle cycles
        n = cyc;
        for (int i = 1; i <= 7; i++) begin
            out_port = 8'(i);
            step();
        end
        check("ovf_full", {31'd0, fifo_full}, 32'd1);
        check("ovf_count", {24'd0, ovf_cnt}, 32'd2);
        steps(5 * (FRAME + 1) + 20);
        for (int k = 0; k < 5; k++)
            check("ovf_frame_byte", {24'd0, decode(n + 2 + k * (FRAME + 1))}, k + 1);

        // saturation of the drop counter
        for (int i = 0; i < 400; i++) begin
            out_port = out_port + 8'd1;
            step();
        end
        check("ovf_saturate", {24'd0, ovf_cnt}, 32'hFF);
        steps(5 * (FRAME + 1));

        // reset during data bit 3 of 0xFF
        do_reset(2, 8'h00);
        step();
        n = cyc; out_port = 8'hFF;
        while (cyc < n + 2 + CPB + 3 * CPB + 1) step();
        check("midframe_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0; out_port = 8'h00;
        step();
        check("midframe_tx", {31'd0, tx}, 32'd1);
        check("midframe_ovf", {24'd0, ovf_cnt}, 32'd0);
        rst_n = 1'b1;
        n = cyc;
        steps(100);
        check("midframe_no_frames", busy_count(n, 100), 32'd0);
        check("midframe_empty", {31'd0, fifo_full}, 32'd0);

        // nonzero port at reset release is pushed
        do_reset(2, 8'h5A);
        n = cyc;
        steps(FRAME + 10);
        check("release_start", {31'd0, hist_tx[n+2]}, 32'd0);
        check("release_byte", {24'd0, decode(n + 2)}, 32'h5A);

`ifdef OUT_PORT_UART_PARITY_EN
        // parity frame for 0x07
        do_reset(2, 8'h00);
        step();
        n = cyc; out_port = 8'h07;
        steps(60);
        check("parity_bit", {31'd0, hist_tx[n + 2 + 36]}, 32'd1);
        for (int k = 40; k < 44; k++)
            check("parity_stop", {31'd0, hist_tx[n + 2 + k]}, 32'd1);
        check("parity_len", busy_count(n, 60), 32'd44);
`endif

        // randomized traffic with occasional resets
        for (int it = 0; it < 250; it++) begin
            cnt = $urandom_range(0, 99);
            if (cnt < 4) begin
                v = 8'($urandom);
                do_reset($urandom_range(1, 3), v);
            end else if (cnt >= 15) begin
                out_port = 8'($urandom);
            end
            hold = (cnt < 40) ? $urandom_range(1, 3) : $urandom_range(1, 50);
            steps(hold);
        end
        steps(DEPTH * (FRAME + 1) + 10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
